// File: rtl/fft_stream_host.sv
// Host-side stimulus/collector for the FFT bridge: streams N source-RAM samples out on AR,
// then collects N results from AW into the result RAM.
module fft_stream_host #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_START,
  input  logic [IDX_WIDTH-1:0]  i_SAMPLES_NUMBER,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERR,
  output logic [IDX_WIDTH-1:0]  o_SRC_INDEX,
  output logic                  o_SRC_READ,
  input  logic [DATA_WIDTH-1:0] i_SRC_DATA,
  output logic                  o_ARVALID,
  output logic [DATA_WIDTH-1:0] o_ARDATA,
  input  logic                  i_ARREADY,
  input  logic                  i_AWVALID,
  input  logic [DATA_WIDTH-1:0] i_AWDATA,
  output logic                  o_AWREADY,
  output logic                  o_DST_WRITE,
  output logic [IDX_WIDTH-1:0]  o_DST_INDEX,
  output logic [DATA_WIDTH-1:0] o_DST_DATA
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESULT, RECV, DONE} state_e;

  state_e                      state_q;
  logic [IDX_WIDTH-1:0]        n_q, rd_cnt_q, tx_cnt_q, rx_cnt_q;
  logic [1:0][DATA_WIDTH-1:0]  fifo_q;
  logic                        wp_q, rp_q, pend_q, err_q;
  logic [1:0]                  occ_q, occ_d;
  logic                        ar_fire, aw_fire, src_read;

  assign o_ARVALID = (occ_q != 2'd0);
  assign o_ARDATA  = o_ARVALID ? fifo_q[rp_q] : '0;
  assign ar_fire   = o_ARVALID & i_ARREADY;
  assign o_AWREADY = (state_q == WAIT_RESULT) || (state_q == RECV);
  assign aw_fire   = i_AWVALID & o_AWREADY;

  // Counting the pop of this cycle lets a read overlap a transfer, sustaining one sample per cycle;
  // occupancy plus in-flight reads never exceeds two.
  assign occ_d    = occ_q + {1'b0, pend_q} - {1'b0, ar_fire};
  assign src_read = (state_q == SEND) && (rd_cnt_q < n_q) && (occ_q != 2'd2) && (occ_d < 2'd2);

  assign o_SRC_READ  = src_read;
  assign o_SRC_INDEX = rd_cnt_q;
  assign o_DST_WRITE = aw_fire;
  assign o_DST_INDEX = rx_cnt_q;
  assign o_DST_DATA  = aw_fire ? i_AWDATA : '0;
  assign o_BUSY      = (state_q != IDLE);
  assign o_DONE      = (state_q == DONE);
  assign o_ERR       = err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      fifo_q   <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      occ_q    <= 2'd0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      pend_q <= src_read;
      occ_q  <= occ_d;
      if (src_read) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (pend_q) begin
        fifo_q[wp_q] <= i_SRC_DATA;
        wp_q         <= ~wp_q;
      end
      if (ar_fire) begin
        rp_q     <= ~rp_q;
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
      if (aw_fire) rx_cnt_q <= rx_cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (i_START) begin
            if (i_SAMPLES_NUMBER != '0) begin
              n_q      <= i_SAMPLES_NUMBER;
              rd_cnt_q <= '0;
              tx_cnt_q <= '0;
              rx_cnt_q <= '0;
              state_q  <= SEND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (ar_fire && (tx_cnt_q == n_q - 1'b1)) state_q <= WAIT_RESULT;
        end
        WAIT_RESULT, RECV: begin
          if (aw_fire) state_q <= (rx_cnt_q == n_q - 1'b1) ? DONE : RECV;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
